// File: rtl/fetch_unit.sv
// fetch_unit: IF stage holding the PC, fetching over a req/ready handshake with a one-entry skid.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises sticky align_fault and halts.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_two,
    output logic        valid,
    output logic        align_fault
);

    typedef enum logic [1:0] {StBoot, StFetch, StHold, StFlush} state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_pc, w_pc_d;
    logic [15:0] r_tgt_pc, w_tgt_pc_d;
    logic        r_skid_valid, w_skid_valid_d;
    logic [15:0] r_skid_instr, w_skid_instr_d;
    logic [15:0] r_skid_pc2, w_skid_pc2_d;
    logic [15:0] r_instr, w_instr_d;
    logic [15:0] r_pc2, w_pc2_d;
    logic        r_valid, w_valid_d;
    logic        r_align_fault, w_align_fault_d;

    logic [15:0] w_pc_inc;
    logic [15:0] w_redir_pc;
    logic        w_misalign;
    logic        w_outstanding;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_redir_pc = redirect_pc;
    assign w_misalign = redirect_pc[0];
`else
    assign w_redir_pc = redirect_pc & 16'hFFFE;
    assign w_misalign = 1'b0;
`endif

    assign w_pc_inc      = r_pc + 16'd2;
    // A request is in flight at the memory and must be allowed to complete
    assign w_outstanding = ((r_state == StFetch) || (r_state == StFlush)) && !imem_ready;

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_tgt_pc_d      = r_tgt_pc;
        w_skid_valid_d  = r_skid_valid;
        w_skid_instr_d  = r_skid_instr;
        w_skid_pc2_d    = r_skid_pc2;
        w_instr_d       = r_instr;
        w_pc2_d         = r_pc2;
        w_valid_d       = r_valid;
        w_align_fault_d = r_align_fault;

        if (r_state == StBoot) begin
            w_state_d = StFetch;
        end else if (r_align_fault) begin
            w_state_d = StHold;
        end else if (redirect_valid) begin
            w_valid_d      = 1'b0;
            w_instr_d      = NOP_WORD;
            w_skid_valid_d = 1'b0;
            if (w_misalign) begin
                w_align_fault_d = 1'b1;
                w_state_d       = StHold;
            end else if (w_outstanding) begin
                w_tgt_pc_d = w_redir_pc;
                w_state_d  = StFlush;
            end else begin
                w_pc_d    = w_redir_pc;
                w_state_d = StFetch;
            end
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (stall) begin
                        if (imem_ready) begin
                            w_skid_valid_d = 1'b1;
                            w_skid_instr_d = imem_rdata;
                            w_skid_pc2_d   = w_pc_inc;
                            w_pc_d         = w_pc_inc;
                            w_state_d      = StHold;
                        end
                    end else if (imem_ready) begin
                        w_instr_d = imem_rdata;
                        w_pc2_d   = w_pc_inc;
                        w_valid_d = 1'b1;
                        w_pc_d    = w_pc_inc;
                    end else begin
                        w_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        w_instr_d      = r_skid_instr;
                        w_pc2_d        = r_skid_pc2;
                        w_valid_d      = r_skid_valid;
                        w_skid_valid_d = 1'b0;
                        w_state_d      = StFetch;
                    end
                end
                StFlush: begin
                    if (imem_ready) begin
                        w_pc_d    = r_tgt_pc;
                        w_state_d = StFetch;
                    end
                end
                default: begin
                    w_state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StBoot;
            r_pc          <= RESET_PC;
            r_tgt_pc      <= RESET_PC;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= 16'h0000;
            r_skid_pc2    <= 16'h0000;
            r_instr       <= NOP_WORD;
            r_pc2         <= 16'h0000;
            r_valid       <= 1'b0;
            r_align_fault <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_tgt_pc      <= w_tgt_pc_d;
            r_skid_valid  <= w_skid_valid_d;
            r_skid_instr  <= w_skid_instr_d;
            r_skid_pc2    <= w_skid_pc2_d;
            r_instr       <= w_instr_d;
            r_pc2         <= w_pc2_d;
            r_valid       <= w_valid_d;
            r_align_fault <= w_align_fault_d;
        end
    end

    assign imem_req    = (r_state == StFetch) || (r_state == StFlush);
    assign imem_addr   = r_pc;
    assign instruction = r_valid ? r_instr : NOP_WORD;
    assign PC_plus_two = r_pc2;
    assign valid       = r_valid;
    assign align_fault = r_align_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: wait-state memory model feeding a scoreboard of
// expected {instruction, PC_plus_two}, plus directed checks for reset, stall, redirect and wrap.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instruction;
    logic [15:0] PC_plus_two;
    logic        valid;
    logic        align_fault;

    fetch_unit #(
        .RESET_PC(16'h0000),
        .NOP_WORD(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .PC_plus_two   (PC_plus_two),
        .valid         (valid),
        .align_fault   (align_fault)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    int          mem_waits = 0;
    int          wait_cnt = 0;
    logic        doomed = 1'b0;
    logic        prev_wait = 1'b0;
    logic        prev_frozen = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] prev_instr = 16'h0000;
    logic [15:0] prev_pc2 = 16'h0000;
    logic        prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        sb_q.delete();
        wait_cnt    = 0;
        doomed      = 1'b0;
        prev_wait   = 1'b0;
        prev_frozen = 1'b0;
    endtask

    // Called at a falling edge: check current outputs, then drive inputs for this cycle.
    task automatic step(input logic s, input logic rv, input logic [15:0] rp);
        logic [31:0] e;
        if (prev_wait) begin
            check_eq("addr_stable", 32'(imem_addr), 32'(prev_addr));
            check_eq("req_held", 32'(imem_req), 32'd1);
        end
        if (prev_frozen) begin
            check_eq("frozen_instr", 32'(instruction), 32'(prev_instr));
            check_eq("frozen_pc2", 32'(PC_plus_two), 32'(prev_pc2));
            check_eq("frozen_valid", 32'(valid), 32'(prev_valid));
        end else if (valid) begin
            check_eq("sb_occupancy", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_instr", 32'(instruction), 32'(e[31:16]));
                check_eq("sb_pc2", 32'(PC_plus_two), 32'(e[15:0]));
            end
        end
        if (!valid) check_eq("bubble_nop", 32'(instruction), 32'(NOP));
        prev_instr = instruction;
        prev_pc2   = PC_plus_two;
        prev_valid = valid;

        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_ready     = imem_req && (wait_cnt >= mem_waits);
        imem_rdata     = imem_ready ? (imem_addr ^ 16'hA5A5) : 16'($urandom);
        if (rv) begin
            sb_q.delete();
            doomed = imem_req && !imem_ready;
        end else if (imem_req && imem_ready) begin
            if (doomed) doomed = 1'b0;
            else sb_q.push_back({imem_rdata, imem_addr + 16'd2});
        end
        prev_wait   = imem_req && !imem_ready;
        prev_addr   = imem_addr;
        prev_frozen = s && !rv;
        wait_cnt    = prev_wait ? wait_cnt + 1 : 0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nv;
        logic        found;
        logic [15:0] s0;

        repeat (3) @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'h0000);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_instr", 32'(instruction), 32'(NOP));
        check_eq("rst_pc2", 32'(PC_plus_two), 32'h0000);
        check_eq("rst_fault", 32'(align_fault), 32'd0);

        // Zero-wait streaming from reset
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("boot_no_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", 32'(imem_addr), 32'h0000);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("i0_instr", 32'(instruction), 32'h0000A5A5);
        check_eq("i0_pc2", 32'(PC_plus_two), 32'h0002);
        check_eq("i0_valid", 32'(valid), 32'd1);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("i1_instr", 32'(instruction), 32'h0000A5A7);
        check_eq("i1_pc2", 32'(PC_plus_two), 32'h0004);
        repeat (6) step(1'b0, 1'b0, 16'h0000);

        // Two wait states: one instruction every third cycle
        mem_waits = 2;
        repeat (6) step(1'b0, 1'b0, 16'h0000);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid) nv++;
            step(1'b0, 1'b0, 16'h0000);
        end
        check_eq("valid_1_in_3", 32'(nv), 32'd10);

        // Four-cycle stall while a zero-wait response returns
        mem_waits = 0;
        repeat (4) step(1'b0, 1'b0, 16'h0000);
        s0 = PC_plus_two;
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_req_drop", 32'(imem_req), 32'd0);
            step(1'b1, 1'b0, 16'h0000);
        end
        step(1'b0, 1'b0, 16'h0000);
        check_eq("skid_valid", 32'(valid), 32'd1);
        check_eq("skid_pc2", 32'(PC_plus_two), 32'(s0 + 16'd2));
        step(1'b0, 1'b0, 16'h0000);
        check_eq("resume_valid", 32'(valid), 32'd1);
        check_eq("resume_pc2", 32'(PC_plus_two), 32'(s0 + 16'd4));
        repeat (3) step(1'b0, 1'b0, 16'h0000);

        // Redirect during an outstanding 3-wait request to 0x0010
        step(1'b0, 1'b1, 16'h0008);
        mem_waits = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 16'h0010 && !doomed && wait_cnt == 0) found = 1'b1;
            else step(1'b0, 1'b0, 16'h0000);
        end
        check_eq("find_0010", 32'(found), 32'd1);
        step(1'b0, 1'b1, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            check_eq("flush_addr", 32'(imem_addr), 32'h0010);
            check_eq("flush_req", 32'(imem_req), 32'd1);
            check_eq("flush_valid", 32'(valid), 32'd0);
            step(1'b0, 1'b0, 16'h0000);
        end
        check_eq("redir_addr", 32'(imem_addr), 32'h0040);
        check_eq("redir_req", 32'(imem_req), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (valid) found = 1'b1;
            else step(1'b0, 1'b0, 16'h0000);
        end
        check_eq("redir_first_valid", 32'(found), 32'd1);
        check_eq("redir_first_pc2", 32'(PC_plus_two), 32'h0042);

        // Reset asserted mid-request drops the request at once
        step(1'b0, 1'b0, 16'h0000);
        check_eq("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        check_eq("mid_rst_addr", 32'(imem_addr), 32'h0000);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reboot_no_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("reboot_req", 32'(imem_req), 32'd1);
        check_eq("reboot_addr", 32'(imem_addr), 32'h0000);

        // Wrap from 0xFFFE
        mem_waits = 0;
        repeat (6) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'hFFFE);
        check_eq("wrap_addr0", 32'(imem_addr), 32'hFFFE);
        check_eq("wrap_bubble", 32'(valid), 32'd0);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("wrap_valid", 32'(valid), 32'd1);
        check_eq("wrap_instr", 32'(instruction), 32'h00005A5B);
        check_eq("wrap_pc2", 32'(PC_plus_two), 32'h0000);
        check_eq("wrap_addr1", 32'(imem_addr), 32'h0000);
        repeat (3) step(1'b0, 1'b0, 16'h0000);

        // Misaligned redirect
        step(1'b0, 1'b1, 16'h0041);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("align_fault_set", 32'(align_fault), 32'd1);
        check_eq("align_halt_req", 32'(imem_req), 32'd0);
        check_eq("align_halt_valid", 32'(valid), 32'd0);
        step(1'b0, 1'b1, 16'h0100);
        repeat (3) step(1'b0, 1'b0, 16'h0000);
        check_eq("align_sticky", 32'(align_fault), 32'd1);
        check_eq("align_still_halted", 32'(imem_req), 32'd0);
        check_eq("align_still_invalid", 32'(valid), 32'd0);
`else
        check_eq("misalign_addr", 32'(imem_addr), 32'h0040);
        check_eq("misalign_no_fault", 32'(align_fault), 32'd0);
        check_eq("misalign_bubble", 32'(valid), 32'd0);
        step(1'b0, 1'b0, 16'h0000);
        check_eq("misalign_valid", 32'(valid), 32'd1);
        check_eq("misalign_pc2", 32'(PC_plus_two), 32'h0042);
        repeat (3) step(1'b0, 1'b0, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
